// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selection constants and the receiver state type.
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs (serial lines, switches, GPIO).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of a synchronized serial line, optional parity,
// valid/ready byte output and single-cycle frame/parity/overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8,
  parameter int PARITY_TYPE  = PARITY_NONE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_in,
  output logic [BITS_N-1:0] data_rx,
  output logic              valid,
  input  logic              ready,
  output logic              frame_error,
  output logic              parity_error,
  output logic              overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(BITS_N + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS_N - 1);
  localparam logic          ODD_SEL  = (PARITY_TYPE == PARITY_ODD);

  logic              rx_s;
  rx_state_t         state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic [BITS_N-1:0] shreg, shreg_n;
  logic [BITS_N-1:0] data_n;
  logic              par_bad, par_bad_n;
  logic              valid_n, ferr_n, perr_n, ovr_n;
  logic              tick;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_in),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      par_bad      <= 1'b0;
      data_rx      <= '0;
      valid        <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_cnt      <= bit_n;
      par_bad      <= par_bad_n;
      data_rx      <= data_n;
      valid        <= valid_n;
      frame_error  <= ferr_n;
      parity_error <= perr_n;
      overrun      <= ovr_n;
    end
  end

  // Shift register is pure datapath; its contents only matter after a full frame.
  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_cnt;
    shreg_n   = shreg;
    par_bad_n = par_bad;
    data_n    = data_rx;
    valid_n   = valid & ~ready;
    ferr_n    = 1'b0;
    perr_n    = 1'b0;
    ovr_n     = 1'b0;
    tick      = (cnt == '0);
    case (state)
      IDLE: begin
        if (!rx_s) begin
          bit_n     = '0;
          cnt_n     = HALF_M1;
          par_bad_n = 1'b0;
          state_n   = START;
        end
      end
      START: begin
        if (tick) begin
          cnt_n   = FULL_M1;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_n   = FULL_M1;
          shreg_n = {rx_s, shreg[BITS_N-1:1]};
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT)
            state_n = (PARITY_TYPE == PARITY_NONE) ? STOP : PARITY;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_n     = FULL_M1;
          par_bad_n = (^shreg) ^ rx_s ^ ODD_SEL;
          state_n   = STOP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          // Errors are mutually exclusive: framing beats parity beats overrun.
          if (!rx_s) begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end else begin
            state_n = IDLE;
            if (par_bad) begin
              perr_n = 1'b1;
            end else if (valid && !ready) begin
              ovr_n = 1'b1;
            end else begin
              data_n  = shreg;
              valid_n = 1'b1;
            end
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: default-rate, parity and fast-rate instances driven by a bit-level
// frame generator, checked against a byte/error-count model of the receiver.
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line [3];
  logic       rdy  [3];
  logic [7:0] drx  [3];
  logic       vld  [3];
  logic       fe   [3];
  logic       pe   [3];
  logic       ov   [3];

  int n_checks = 0;
  int n_fail   = 0;
  int gotq [$];
  int expq [$];
  int got_fe [3], got_pe [3], got_ov [3], vcyc [3];
  int exp_fe [3], exp_pe [3], exp_ov [3];
  bit held_v [3];
  logic [7:0] held_b [3];

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(434), .BITS_N(8), .PARITY_TYPE(0)) u_def (
    .clk(clk), .rst(rst), .uart_in(line[0]), .data_rx(drx[0]), .valid(vld[0]),
    .ready(rdy[0]), .frame_error(fe[0]), .parity_error(pe[0]), .overrun(ov[0]));

  uart_rx #(.CLKS_PER_BIT(16), .BITS_N(8), .PARITY_TYPE(2)) u_par (
    .clk(clk), .rst(rst), .uart_in(line[1]), .data_rx(drx[1]), .valid(vld[1]),
    .ready(rdy[1]), .frame_error(fe[1]), .parity_error(pe[1]), .overrun(ov[1]));

  uart_rx #(.CLKS_PER_BIT(16), .BITS_N(8), .PARITY_TYPE(0)) u_fast (
    .clk(clk), .rst(rst), .uart_in(line[2]), .data_rx(drx[2]), .valid(vld[2]),
    .ready(rdy[2]), .frame_error(fe[2]), .parity_error(pe[2]), .overrun(ov[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i]) vcyc[i]++;
      if (vld[i] && rdy[i]) gotq.push_back(i * 256 + int'(drx[i]));
      if (fe[i]) got_fe[i]++;
      if (pe[i]) got_pe[i]++;
      if (ov[i]) got_ov[i]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(string tag, int obs, int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(int i, logic v, int cycles);
    line[i] = v;
    repeat (cycles) tick();
  endtask

  // Line-level frame plus the receiver's expected reaction to it.
  task automatic send_frame(int i, int cpb, logic [7:0] b, int ptype, bit flip, int stop_low);
    logic p;
    drive(i, 1'b0, cpb);
    for (int k = 0; k < 8; k++) drive(i, b[k], cpb);
    if (ptype != 0) begin
      p = ($countones(b) % 2 == 1) ^ (ptype == 1);
      drive(i, p ^ flip, cpb);
    end
    if (stop_low > 0) drive(i, 1'b0, stop_low * cpb);
    drive(i, 1'b1, cpb);
    if (stop_low > 0) exp_fe[i]++;
    else if (ptype != 0 && flip) exp_pe[i]++;
    else if (rdy[i]) expq.push_back(i * 256 + int'(b));
    else if (held_v[i]) exp_ov[i]++;
    else begin
      held_v[i] = 1'b1;
      held_b[i] = b;
    end
  endtask

  task automatic checkpoint(string tag);
    check({tag, ":nbytes"}, gotq.size(), expq.size());
    while (gotq.size() > 0 && expq.size() > 0)
      check({tag, ":byte"}, gotq.pop_front(), expq.pop_front());
    gotq.delete();
    expq.delete();
    for (int i = 0; i < 3; i++) begin
      check({tag, ":frame_err"}, got_fe[i], exp_fe[i]);
      check({tag, ":parity_err"}, got_pe[i], exp_pe[i]);
      check({tag, ":overrun"}, got_ov[i], exp_ov[i]);
    end
  endtask

  initial begin
    string json;
    logic [7:0] bb;
    int v0;
    json = "{\"T\":1,\"L\":0.5,\"R\":0.5}\n";
    for (int i = 0; i < 3; i++) begin
      line[i] = 1'b1; rdy[i] = 1'b1; held_v[i] = 1'b0; held_b[i] = '0;
      got_fe[i] = 0; got_pe[i] = 0; got_ov[i] = 0; vcyc[i] = 0;
      exp_fe[i] = 0; exp_pe[i] = 0; exp_ov[i] = 0;
    end
    rst = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("reset_valid", vld[i], 0);
      check("reset_data", drx[i], 0);
      check("reset_errs", {fe[i], pe[i], ov[i]}, 0);
    end

    // Short glitch, then a frame starting soon after the false-start sample point.
    drive(0, 1'b0, 100);
    drive(0, 1'b1, 120);
    checkpoint("glitch");
    v0 = vcyc[0];
    send_frame(0, 434, 8'h7B, 0, 1'b0, 0);
    drive(0, 1'b1, 20);
    check("valid_width", vcyc[0] - v0, 1);
    checkpoint("byte_7b");

    send_frame(0, 434, 8'h55, 0, 1'b0, 2);
    send_frame(0, 434, 8'h0A, 0, 1'b0, 0);
    drive(0, 1'b1, 20);
    checkpoint("frame_err");

    rdy[0] = 1'b0;
    send_frame(0, 434, 8'h22, 0, 1'b0, 0);
    send_frame(0, 434, 8'h3A, 0, 1'b0, 0);
    drive(0, 1'b1, 10);
    check("ovr_valid", vld[0], 1);
    check("ovr_data", drx[0], 8'h22);
    checkpoint("overrun");
    rdy[0] = 1'b1;
    expq.push_back(int'(held_b[0]));
    held_v[0] = 1'b0;
    tick();
    rdy[0] = 1'b0;
    tick();
    check("ovr_valid_clear", vld[0], 0);
    rdy[0] = 1'b1;
    checkpoint("ovr_drain");

    // Transmitter clock 4% slow and 4% fast.
    send_frame(0, 417, 8'hC3, 0, 1'b0, 0);
    send_frame(0, 451, 8'h96, 0, 1'b0, 0);
    drive(0, 1'b1, 20);
    checkpoint("baud_tol");

    send_frame(1, 16, 8'h31, 2, 1'b1, 0);
    drive(1, 1'b1, 10);
    check("par_bad_valid", vld[1], 0);
    send_frame(1, 16, 8'h31, 2, 1'b0, 0);
    drive(1, 1'b1, 10);
    checkpoint("parity");
    for (int n = 0; n < 12; n++) begin
      bb = 8'($urandom_range(0, 255));
      send_frame(1, 16, bb, 2, ($urandom_range(0, 3) == 0), 0);
      drive(1, 1'b1, $urandom_range(0, 20));
    end
    drive(1, 1'b1, 10);
    checkpoint("parity_rand");

    for (int n = 0; n < 16; n++) begin
      bb = 8'($urandom_range(0, 255));
      send_frame(2, 16, bb, 0, 1'b0, 0);
      drive(2, 1'b1, $urandom_range(0, 20));
    end
    drive(2, 1'b1, 10);
    checkpoint("fast_rand");

    for (int n = 0; n < json.len(); n++) begin
      bb = json[n];
      send_frame(2, 16, bb, 0, 1'b0, 0);
    end
    drive(2, 1'b1, 10);
    checkpoint("json");

    for (int n = 0; n < 4; n++) begin
      bb = json[n];
      send_frame(2, 16, bb, 0, 1'b0, 0);
    end
    bb = json[4];
    drive(2, 1'b0, 16);
    for (int k = 0; k < 3; k++) drive(2, bb[k], 16);
    drive(2, bb[3], 8);
    rst = 1'b1;
    line[2] = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    drive(2, 1'b1, 40);
    check("rst_no_valid", vld[2], 0);
    send_frame(2, 16, bb, 0, 1'b0, 0);
    drive(2, 1'b1, 10);
    checkpoint("mid_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
